// File: rtl/decoder_3.sv
// Registered 3-to-8 line decoder with enable and selectable output polarity.
// Select index is {a,b,c}; x updates only on the rising clk edge.
module decoder_3 #(
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic [7:0] x
);

    // XOR mask that flips the active-high encoding into one-cold when needed.
    localparam logic [7:0] POL_MASK = ACTIVE_HIGH ? 8'h00 : 8'hFF;

    logic [2:0] sel;
    logic [7:0] onehot;

    assign sel = {a, b, c};

    always_comb begin
        onehot = 8'h00;
        case (sel)
            3'd0: onehot = 8'b0000_0001;
            3'd1: onehot = 8'b0000_0010;
            3'd2: onehot = 8'b0000_0100;
            3'd3: onehot = 8'b0000_1000;
            3'd4: onehot = 8'b0001_0000;
            3'd5: onehot = 8'b0010_0000;
            3'd6: onehot = 8'b0100_0000;
            3'd7: onehot = 8'b1000_0000;
            default: onehot = 8'h00;
        endcase
    end

    // Reset wins over enable; a disabled or reset edge loads the all-inactive value.
    always_ff @(posedge clk) begin
        if (rst)
            x <= POL_MASK;
        else if (en)
            x <= onehot ^ POL_MASK;
        else
            x <= POL_MASK;
    end

endmodule

// File: tb/tb_decoder_3.sv
// Self-checking bench for decoder_3: directed cases plus a random stream,
// both polarities checked against a shift-based reference model.
module tb_decoder_3;

    logic       clk;
    logic       rst;
    logic       en;
    logic       a;
    logic       b;
    logic       c;
    logic [7:0] x_hi;
    logic [7:0] x_lo;

    int total = 0;
    int bad   = 0;

    decoder_3 #(.ACTIVE_HIGH(1'b1)) dut_hi (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c), .x(x_hi)
    );

    decoder_3 #(.ACTIVE_HIGH(1'b0)) dut_lo (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c), .x(x_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: active line = 1 shifted left by the select value, nothing when idle.
    function automatic logic [7:0] model(input logic r, input logic e, input logic [2:0] s);
        logic [7:0] one;
        one = 8'd1;
        if (r || !e)
            return 8'h00;
        return one << s;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive inputs, clock once, then check both instances against the model.
    task automatic step(input string tag, input logic r, input logic e, input logic [2:0] s);
        logic [7:0] exp;
        rst = r; en = e; {a, b, c} = s;
        exp = model(r, e, s);
        @(posedge clk);
        #1;
        chk({tag, "_hi"}, x_hi, exp);
        chk({tag, "_lo"}, x_lo, ~exp);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;

        step("reset", 1'b1, 1'b1, 3'd6);

        for (int i = 0; i < 8; i++)
            step($sformatf("sweep%0d", i), 1'b0, 1'b1, 3'(i));

        // Spot checks with literal expectations.
        step("rst_pri", 1'b1, 1'b1, 3'b101);
        chk("rst_pri_lit", x_hi, 8'h00);
        step("rst_rel", 1'b0, 1'b1, 3'b101);
        chk("rst_rel_lit", x_hi, 8'h20);
        step("en_off", 1'b0, 1'b0, 3'b011);
        chk("en_off_lit", x_hi, 8'h00);
        step("en_on", 1'b0, 1'b1, 3'b011);
        chk("en_on_lit", x_hi, 8'h08);
        step("pol", 1'b0, 1'b1, 3'b010);
        chk("pol_lit", x_lo, 8'hFB);
        step("pol_rst", 1'b1, 1'b1, 3'b010);
        chk("pol_rst_lit", x_lo, 8'hFF);

        // Mid-cycle select change must not reach x before the next edge.
        step("mid_a", 1'b0, 1'b1, 3'b000);
        #3;
        {a, b, c} = 3'b111;
        #2;
        chk("mid_hold", x_hi, 8'h01);
        @(posedge clk);
        #1;
        chk("mid_next", x_hi, 8'h80);

        // Random stream with popcount invariant.
        for (int i = 0; i < 300; i++) begin
            logic r, e;
            logic [2:0] s;
            r = ($urandom_range(0, 15) == 0);
            e = ($urandom_range(0, 3) != 0);
            s = 3'($urandom_range(0, 7));
            step("rand", r, e, s);
            chk("rand_pop", 8'($countones(x_hi)), (!r && e) ? 8'd1 : 8'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
